// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the pipeline hazard controller.
//   hz_state_t      - hazard FSM state encoding (RUN/FLUSH/MEMWAIT)
//   ST_*            - 2-bit state constants; the state register is plain
//                     logic [1:0] so the unused code 3 stays representable
//   XZR             - zero register index, never a real data dependency
//   is_load_use()   - load-use dependency between ID/EX and IF/ID
package cpu_pkg;

  typedef enum logic [1:0] {
    HZ_RUN     = 2'd0,
    HZ_FLUSH   = 2'd1,
    HZ_MEMWAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] ST_RUN     = HZ_RUN;
  localparam logic [1:0] ST_FLUSH   = HZ_FLUSH;
  localparam logic [1:0] ST_MEMWAIT = HZ_MEMWAIT;

  localparam logic [4:0] XZR = 5'd31;

  // A load into XZR produces nothing to wait for.
  function automatic logic is_load_use(
    input logic       ldur,
    input logic       reg_write,
    input logic [4:0] rd,
    input logic [4:0] rn,
    input logic [4:0] rm,
    input logic       uses_rm
  );
    return ldur & reg_write & (rd != XZR) &
           ((rd == rn) | (uses_rm & (rd == rm)));
  endfunction

endpackage

// File: rtl/hz_sat_counter.sv
// hz_sat_counter: up-counter that sticks at all-ones instead of wrapping.
//   clk, rst_n - clock, async active-low reset (clears count)
//   inc        - count up by one this cycle
//   clr        - synchronous clear, wins over inc
//   cnt        - current count
module hz_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + WIDTH'(1);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage core.
//   Inputs : clk, rst_n; IF/ID source regs (IFID_Rn/Rm, IFID_uses_Rm);
//            ID/EX load info (IDEX_ldur, IDEX_RegWrite, IDEX_Rd);
//            br_taken from EX; dmem_req/dmem_ready from MEM.
//   Outputs: pc_en, IFID_en, IDEX_en, EXMEM_en (register enables),
//            IFID_flush, IDEX_bubble (squash controls), stall_cnt
//            (saturating stall-cycle count), mem_err (sticky timeout),
//            state (FSM state).
// Priority: memory stall > taken branch > load-use. Controls are
// combinational from state + inputs; state and counters are registered.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IFID_Rn,
  input  logic [4:0]       IFID_Rm,
  input  logic             IFID_uses_Rm,
  input  logic             IDEX_ldur,
  input  logic             IDEX_RegWrite,
  input  logic [4:0]       IDEX_Rd,
  input  logic             br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             IFID_en,
  output logic             IDEX_en,
  output logic             EXMEM_en,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             mem_err,
  output logic [1:0]       state
);

  // Wide enough to hold MEM_TIMEOUT itself.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              r_mem_err;
  logic              w_mem_stall;
  logic              w_load_use;
  logic              w_wait_inc;
  logic              w_wait_clr;
  logic [WAIT_W-1:0] w_wait_cnt;

  assign w_mem_stall = dmem_req & ~dmem_ready;
  assign w_load_use  = is_load_use(IDEX_ldur, IDEX_RegWrite, IDEX_Rd,
                                   IFID_Rn, IFID_Rm, IFID_uses_Rm);

  // Reset forces the RUN idle controls regardless of inputs.
  always_comb begin
    w_next      = ST_RUN;
    pc_en       = 1'b1;
    IFID_en     = 1'b1;
    IDEX_en     = 1'b1;
    EXMEM_en    = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_RUN, ST_FLUSH: begin
          if (w_mem_stall) begin
            {pc_en, IFID_en, IDEX_en, EXMEM_en} = 4'b0000;
            w_next = ST_MEMWAIT;
          end else if (br_taken) begin
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
            w_next      = ST_FLUSH;
          end else if (r_state == ST_RUN && w_load_use) begin
            // Hold PC and IF/ID one cycle, bubble into ID/EX.
            pc_en       = 1'b0;
            IFID_en     = 1'b0;
            IDEX_bubble = 1'b1;
          end
        end
        ST_MEMWAIT: begin
          if (!dmem_ready) begin
            {pc_en, IFID_en, IDEX_en, EXMEM_en} = 4'b0000;
            w_next = ST_MEMWAIT;
          end
        end
        default: ; // code 3: idle controls, back to RUN
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_next;
  end

  hz_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~pc_en),
    .clr   (1'b0),
    .cnt   (stall_cnt)
  );

  // Counts cycles actually spent waiting in MEMWAIT; restarts on entry.
  assign w_wait_inc = (r_state == ST_MEMWAIT) & ~dmem_ready;
  assign w_wait_clr = w_mem_stall & (r_state != ST_MEMWAIT);

  hz_sat_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_wait_inc),
    .clr   (w_wait_clr),
    .cnt   (w_wait_cnt)
  );

  // Set on the same edge the wait count reaches MEM_TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_mem_err <= 1'b0;
    else if (w_wait_inc && w_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))
      r_mem_err <= 1'b1;
  end

  assign mem_err = r_mem_err;
  assign state   = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 64;
  localparam logic [5:0] IDLE = 6'b111100; // {pc,ifid,idex,exmem,flush,bubble}

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       IFID_Rn, IFID_Rm, IDEX_Rd;
  logic             IFID_uses_Rm, IDEX_ldur, IDEX_RegWrite;
  logic             br_taken, dmem_req, dmem_ready;
  logic             pc_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic             mem_err;
  logic [1:0]       state;

  int checks = 0;
  int passed = 0;

  // reference model state
  int m_state, m_stall, m_wait;
  bit m_err;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_Rn(IFID_Rn), .IFID_Rm(IFID_Rm), .IFID_uses_Rm(IFID_uses_Rm),
    .IDEX_ldur(IDEX_ldur), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_Rd(IDEX_Rd),
    .br_taken(br_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en), .EXMEM_en(EXMEM_en),
    .IFID_flush(IFID_flush), .IDEX_bubble(IDEX_bubble),
    .stall_cnt(stall_cnt), .mem_err(mem_err), .state(state)
  );

  function automatic logic [5:0] outs();
    return {pc_en, IFID_en, IDEX_en, EXMEM_en, IFID_flush, IDEX_bubble};
  endfunction

  function automatic bit m_lu();
    return IDEX_ldur && IDEX_RegWrite && IDEX_Rd != 5'd31 &&
           (IDEX_Rd == IFID_Rn || (IFID_uses_Rm && IDEX_Rd == IFID_Rm));
  endfunction

  // Expected controls from the rule list: reset idle, waiting, mem stall,
  // branch, load-use (RUN only), idle.
  function automatic logic [5:0] m_comb();
    if (!rst_n)                      return IDLE;
    if (m_state == 2)                return dmem_ready ? IDLE : 6'b000000;
    if (dmem_req && !dmem_ready)     return 6'b000000;
    if (br_taken)                    return 6'b111111;
    if (m_state == 0 && m_lu())      return 6'b001101;
    return IDLE;
  endfunction

  function automatic int m_next();
    if (m_state == 2)                return dmem_ready ? 0 : 2;
    if (dmem_req && !dmem_ready)     return 2;
    if (br_taken)                    return 1;
    return 0;
  endfunction

  task automatic m_reset();
    m_state = 0; m_stall = 0; m_wait = 0; m_err = 0;
  endtask

  // Advance model with the current inputs, then the clock.
  task automatic tick();
    logic [5:0] e;
    if (rst_n) begin
      e = m_comb();
      if (!e[5] && m_stall < (1 << CNT_W) - 1) m_stall++;
      if (m_state == 2 && !dmem_ready) begin
        m_wait++;
        if (m_wait >= TIMEOUT) m_err = 1;
      end else if (dmem_req && !dmem_ready) m_wait = 0;
      m_state = m_next();
    end else m_reset();
    @(posedge clk); #1;
  endtask

  task automatic set_idle();
    IFID_Rn = 5'd1; IFID_Rm = 5'd2; IFID_uses_Rm = 1'b0;
    IDEX_ldur = 1'b0; IDEX_RegWrite = 1'b0; IDEX_Rd = 5'd0;
    br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0; m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_reset();
    // hostile inputs: every hazard asserted at once
    IFID_Rn = 5'd5; IFID_Rm = 5'd5; IFID_uses_Rm = 1'b1;
    IDEX_ldur = 1'b1; IDEX_RegWrite = 1'b1; IDEX_Rd = 5'd5;
    br_taken = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    #2;
    checks++; if (outs() !== IDLE) $display("FAIL reset_ctrl got=%b exp=%b", outs(), IDLE); else passed++;
    @(posedge clk); #1;
    checks++; if (state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state); else passed++;
    checks++; if (stall_cnt !== '0) $display("FAIL reset_stall got=%0d exp=0", stall_cnt); else passed++;
    checks++; if (mem_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", mem_err); else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    IDEX_ldur = 1'b1; IDEX_RegWrite = 1'b1; IDEX_Rd = 5'd5; IFID_Rn = 5'd5;
    #2;
    checks++; if (outs() !== 6'b001101) $display("FAIL lu_ctrl got=%b exp=001101", outs()); else passed++;
    tick();
    IDEX_ldur = 1'b0; IDEX_RegWrite = 1'b0; // bubble now in ID/EX
    #2;
    checks++; if (outs() !== IDLE) $display("FAIL lu_after got=%b exp=%b", outs(), IDLE); else passed++;
    checks++; if (state !== 2'd0) $display("FAIL lu_state got=%0d exp=0", state); else passed++;
    checks++; if (stall_cnt !== 4'd1) $display("FAIL lu_stall got=%0d exp=1", stall_cnt); else passed++;
    tick();
  endtask

  task automatic test_no_stall();
    do_reset();
    IDEX_ldur = 1'b1; IDEX_RegWrite = 1'b1; IDEX_Rd = 5'd31; IFID_Rn = 5'd31;
    #2;
    checks++; if (outs() !== IDLE) $display("FAIL xzr_load got=%b exp=%b", outs(), IDLE); else passed++;
    tick();
    IDEX_Rd = 5'd5; IFID_Rn = 5'd3; IFID_Rm = 5'd5; IFID_uses_Rm = 1'b0;
    #2;
    checks++; if (outs() !== IDLE) $display("FAIL rm_unused got=%b exp=%b", outs(), IDLE); else passed++;
    tick();
    IFID_uses_Rm = 1'b1;
    #2;
    checks++; if (outs() !== 6'b001101) $display("FAIL rm_used got=%b exp=001101", outs()); else passed++;
    tick();
    set_idle();
    IDEX_RegWrite = 1'b0; IDEX_ldur = 1'b1; IDEX_Rd = 5'd1;
    #2;
    checks++; if (outs() !== IDLE) $display("FAIL no_regwrite got=%b exp=%b", outs(), IDLE); else passed++;
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    IDEX_ldur = 1'b1; IDEX_RegWrite = 1'b1; IDEX_Rd = 5'd7; IFID_Rn = 5'd7;
    br_taken = 1'b1;
    #2;
    checks++; if (outs() !== 6'b111111) $display("FAIL br_lu_ctrl got=%b exp=111111", outs()); else passed++;
    tick();
    checks++; if (state !== 2'd1) $display("FAIL br_state got=%0d exp=1", state); else passed++;
    // second branch while flushing: flush again, stay
    #2;
    checks++; if (outs() !== 6'b111111) $display("FAIL br_again got=%b exp=111111", outs()); else passed++;
    tick();
    checks++; if (state !== 2'd1) $display("FAIL br_again_state got=%0d exp=1", state); else passed++;
    br_taken = 1'b0; // load-use still visible, suppressed in FLUSH
    #2;
    checks++; if (outs() !== IDLE) $display("FAIL flush_lu_supp got=%b exp=%b", outs(), IDLE); else passed++;
    tick();
    checks++; if (state !== 2'd0) $display("FAIL flush_exit got=%0d exp=0", state); else passed++;
    checks++; if (stall_cnt !== 4'd0) $display("FAIL br_stall got=%0d exp=0", stall_cnt); else passed++;
    set_idle();
  endtask

  task automatic test_memwait();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (outs() !== 6'b000000) $display("FAIL mw_hold%0d got=%b exp=000000", i, outs()); else passed++;
      tick();
      checks++; if (state !== 2'd2) $display("FAIL mw_state%0d got=%0d exp=2", i, state); else passed++;
    end
    dmem_ready = 1'b1;
    #2;
    checks++; if (outs() !== IDLE) $display("FAIL mw_ready got=%b exp=%b", outs(), IDLE); else passed++;
    tick();
    dmem_req = 1'b0;
    checks++; if (state !== 2'd0) $display("FAIL mw_exit got=%0d exp=0", state); else passed++;
    checks++; if (stall_cnt !== 4'd3) $display("FAIL mw_stall got=%0d exp=3", stall_cnt); else passed++;
    checks++; if (mem_err !== 1'b0) $display("FAIL mw_err got=%b exp=0", mem_err); else passed++;
  endtask

  // 70 not-ready cycles: cycle 0 enters, cycles 1..69 wait in MEMWAIT.
  task automatic test_timeout_sat();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 70; i++) begin
      #2;
      if (mem_err !== (i >= TIMEOUT + 1)) begin
        checks++; $display("FAIL to_err cyc=%0d got=%b exp=%b", i, mem_err, i >= TIMEOUT + 1);
      end else begin checks++; passed++; end
      if (stall_cnt !== CNT_W'(i > 15 ? 15 : i)) begin
        checks++; $display("FAIL to_sat cyc=%0d got=%0d", i, stall_cnt);
      end else begin checks++; passed++; end
      tick();
    end
    dmem_ready = 1'b1;
    #2;
    checks++; if (outs() !== IDLE) $display("FAIL to_ready got=%b exp=%b", outs(), IDLE); else passed++;
    tick();
    set_idle();
    tick();
    checks++; if (mem_err !== 1'b1) $display("FAIL to_sticky got=%b exp=1", mem_err); else passed++;
    checks++; if (stall_cnt !== 4'd15) $display("FAIL to_satend got=%0d exp=15", stall_cnt); else passed++;
  endtask

  // Runs straight after the timeout test, so mem_err is still set.
  task automatic test_reset_midwait();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0) $display("FAIL rmw_state got=%0d exp=0", state); else passed++;
    checks++; if (stall_cnt !== '0) $display("FAIL rmw_stall got=%0d exp=0", stall_cnt); else passed++;
    checks++; if (mem_err !== 1'b0) $display("FAIL rmw_err got=%b exp=0", mem_err); else passed++;
    checks++; if (outs() !== IDLE) $display("FAIL rmw_ctrl got=%b exp=%b", outs(), IDLE); else passed++;
    m_reset();
    tick();
    set_idle();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [4:0] pool [4] = '{5'd3, 5'd4, 5'd5, 5'd31};
    logic [5:0] e;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      IFID_Rn       = pool[$urandom_range(0, 3)];
      IFID_Rm       = pool[$urandom_range(0, 3)];
      IDEX_Rd       = pool[$urandom_range(0, 3)];
      IFID_uses_Rm  = 1'($urandom_range(0, 1));
      IDEX_ldur     = 1'($urandom_range(0, 1));
      IDEX_RegWrite = ($urandom_range(0, 3) != 0);
      br_taken      = (m_state != 2) && ($urandom_range(0, 4) == 0);
      dmem_req      = ($urandom_range(0, 3) == 0);
      dmem_ready    = ($urandom_range(0, 4) < 3);
      #2;
      e = m_comb();
      checks++; if (outs() !== e) $display("FAIL rnd_ctrl cyc=%0d got=%b exp=%b", i, outs(), e); else passed++;
      checks++; if (state !== 2'(m_state)) $display("FAIL rnd_state cyc=%0d got=%0d exp=%0d", i, state, m_state); else passed++;
      checks++; if (stall_cnt !== CNT_W'(m_stall)) $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", i, stall_cnt, m_stall); else passed++;
      checks++; if (mem_err !== m_err) $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, mem_err, m_err); else passed++;
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    m_reset();
    #1;
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_memwait();
    test_timeout_sat();
    test_reset_midwait();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, as the width of the stall performance counter.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 64, as the maximum MEMWAIT cycles before a memory error is flagged.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port IFID_Rn, input, 5 bits: first source register of the instruction in decode.
REQ-007 Port IFID_Rm, input, 5 bits: second source register of the instruction in decode.
REQ-008 Port IFID_uses_Rm, input, 1 bit: the decode instruction reads Rm.
REQ-009 Port IDEX_ldur, IDEX_RegWrite, input, 1 bit each: the ID/EX stage holds a load that writes a register.
REQ-010 Port IDEX_Rd, input, 5 bits: destination register of the ID/EX instruction.
REQ-011 Port br_taken, input, 1 bit: a taken branch is resolved in EX this cycle.
REQ-012 Port dmem_req, input, 1 bit: the MEM stage issues an access this cycle.
REQ-013 Port dmem_ready, input, 1 bit: data memory completes the access this cycle.
REQ-014 Port pc_en, IFID_en, IDEX_en, EXMEM_en, output, 1 bit each: pipeline register enables.
REQ-015 Port IFID_flush, IDEX_bubble, output, 1 bit each: clear IF/ID and force ID/EX controls to zero.
REQ-016 Port stall_cnt, output, CNT_W bits: saturating count of stall cycles.
REQ-017 Port mem_err, output, 1 bit: sticky memory-timeout flag.
REQ-018 Port state, output, 2 bits: current FSM state.

Function
REQ-019 The FSM SHALL have states RUN=0, FLUSH=1, MEMWAIT=2; encoding 3 is unreachable, and the FSM SHALL recover from it to RUN on the next edge.
REQ-020 Enables and flush controls SHALL be combinational from the state and inputs, with zero-cycle latency; the state and counters SHALL be registered.
REQ-021 Load-use SHALL be defined as IDEX_ldur & IDEX_RegWrite & IDEX_Rd!=31 & (IDEX_Rd==IFID_Rn | (IFID_uses_Rm & IDEX_Rd==IFID_Rm)).
REQ-022 Conditions SHALL be prioritised as memory stall > taken branch > load-use.
REQ-023 Memory stall condition: dmem_req & !dmem_ready in any state. All four enables SHALL be 0 and the flush and bubble controls 0. The next state SHALL be MEMWAIT.
REQ-024 In MEMWAIT, all enables SHALL stay 0 until dmem_ready=1. In that cycle, all enables SHALL be 1 and the next state SHALL be RUN.
REQ-025 In MEMWAIT, a wait counter SHALL increment each cycle. When it reaches MEM_TIMEOUT, mem_err SHALL set and remain set until reset; the wait SHALL continue.
REQ-026 The wait counter SHALL clear on entry to MEMWAIT.
REQ-027 Taken branch in RUN with no memory stall: pc_en=1, IFID_flush=1, IDEX_bubble=1, and IFID_en, IDEX_en and EXMEM_en SHALL be 1. The next state SHALL be FLUSH.
REQ-028 In FLUSH, load-use detection SHALL be suppressed and all enables SHALL be 1. The next state SHALL be RUN, unless another branch is taken, in which case the block SHALL repeat the flush and stay in FLUSH.
REQ-029 Load-use in RUN with no branch and no memory stall: pc_en=0, IFID_en=0, IDEX_bubble=1, IDEX_en=1, EXMEM_en=1, and the state SHALL stay RUN. This inserts exactly one bubble.
REQ-030 stall_cnt SHALL increment on every cycle in which pc_en=0. It SHALL saturate at all-ones and not wrap.
REQ-031 Idle RUN cycles SHALL drive all enables 1 and IFID_flush=0, IDEX_bubble=0.

Reset
REQ-032 While rst_n=0, asynchronously: state=RUN, stall_cnt=0, the wait counter=0, and mem_err=0.
REQ-033 Combinational outputs during reset SHALL equal the RUN idle values.
REQ-034 Reset asserted mid-MEMWAIT SHALL abandon the wait, with no mem_err.

Structure
REQ-035 Package cpu_pkg SHALL hold the hz_state_t enum and constant XZR=5'd31.
REQ-036 The saturating counter SHALL be one sub-module, hz_sat_counter (parameter width; inputs inc and clr), instantiated for stall_cnt and the wait counter.

Verification
REQ-037 Scenario: IDEX_ldur=1, IDEX_RegWrite=1, IDEX_Rd=5, IFID_Rn=5. Required: one cycle with pc_en=0, IFID_en=0, IDEX_bubble=1, then idle; stall_cnt=1.
REQ-038 Scenario: IDEX_Rd=31 load with IFID_Rn=31. Required: no stall. Scenario: IFID_Rm=5 with IFID_uses_Rm=0. Required: no stall.
REQ-039 Scenario: br_taken together with load-use in the same cycle. Required: IFID_flush=1, IDEX_bubble=1, pc_en=1, state=FLUSH; the next cycle has no stall.
REQ-040 Scenario: dmem_req=1 with dmem_ready low for 3 cycles. Required: all enables 0 for 3 cycles, state=2, then all enables 1 on the ready cycle; stall_cnt=3.
REQ-041 Scenario: dmem_ready low for 70 cycles with MEM_TIMEOUT=64. Required: mem_err rises after the 64th wait cycle and stays set after the wait ends; CNT_W=4 saturates at 15.
REQ-042 Scenario: rst_n dropped mid-MEMWAIT. Required: immediate state=0, stall_cnt=0, mem_err=0, all enables 1.
